// File: rtl/core_seq_if.sv
// core_seq_if: tile request, core status and instruction bus between a host and core_seq.
// master drives the request side; slave is the sequencer.
interface core_seq_if #(
    parameter int unsigned col     = 8,
    parameter int unsigned addr_bw = 11
);
    logic               start;
    logic [addr_bw-1:0] w_base;
    logic [addr_bw-1:0] a_base;
    logic [addr_bw-1:0] p_base;
    logic [addr_bw-1:0] n_act;
    logic [col-1:0]     ofifo_valid;
    logic [33:0]        inst;
    logic               busy;
    logic               done;

    modport master (
        output start, w_base, a_base, p_base, n_act, ofifo_valid,
        input  inst, busy, done
    );

    modport slave (
        input  start, w_base, a_base, p_base, n_act, ofifo_valid,
        output inst, busy, done
    );
endinterface

// File: rtl/core_seq.sv
// core_seq: per-tile sequencer producing the registered 34-bit core instruction word.
// Define CORE_SEQ_ACC_EN to add the ACC read/write-back phase between DRAIN and DONE.
module core_seq #(
    parameter int unsigned row     = 8,
    parameter int unsigned col     = 8,
    parameter int unsigned addr_bw = 11
) (
    input logic       clk,
    input logic       reset,
    core_seq_if.slave bus
);
    localparam int unsigned CW = (addr_bw + 1 > $clog2(row + col + 1)) ?
                                 addr_bw + 1 : $clog2(row + col + 1);
    // Both SRAMs deselected, write-enables inactive, everything else low.
    localparam logic [33:0] IdleInst = 34'h1_800C_0000;

`ifdef CORE_SEQ_ACC_EN
    typedef enum logic [3:0] {
        StIdle, StWrd, StWker, StArd, StExec, StWaito, StDrain, StAcc, StDone
    } state_e;
`else
    typedef enum logic [3:0] {
        StIdle, StWrd, StWker, StArd, StExec, StWaito, StDrain, StDone
    } state_e;
`endif

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CW-1:0]      wcnt_q, wcnt_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic [addr_bw-1:0] w_base_q, w_base_d;
    logic [addr_bw-1:0] a_base_q, a_base_d;
    logic [addr_bw-1:0] p_base_q, p_base_d;
    logic [addr_bw-1:0] n_act_q, n_act_d;
    logic [33:0]        inst_q, inst_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CW-1:0]      n_ext_q, n_ext_d;
    logic               all_valid;
`ifdef CORE_SEQ_ACC_EN
    logic               ph_q, ph_d;
`endif

    assign all_valid = &bus.ofifo_valid;
    assign n_ext_q   = CW'(n_act_q);
    assign n_ext_d   = CW'(n_act_d);

    // Next-state: counters index the beat currently on the bus.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wcnt_d   = wcnt_q;
        rd_d     = 1'b0;
        wr_d     = 1'b0;
        w_base_d = w_base_q;
        a_base_d = a_base_q;
        p_base_d = p_base_q;
        n_act_d  = n_act_q;
`ifdef CORE_SEQ_ACC_EN
        ph_d     = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    w_base_d = bus.w_base;
                    a_base_d = bus.a_base;
                    p_base_d = bus.p_base;
                    n_act_d  = bus.n_act;
                    cnt_d    = '0;
                    wcnt_d   = '0;
                    state_d  = (bus.n_act == '0) ? StDone : StWrd;
                end
            end
            StWrd: begin
                if (cnt_q == CW'(row)) begin
                    state_d = StWker;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWker: begin
                if (cnt_q == CW'(row + col - 1)) begin
                    state_d = StArd;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StArd: begin
                if (cnt_q == n_ext_q) begin
                    state_d = StExec;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StExec: begin
                if (cnt_q == n_ext_q - 1'b1) begin
                    state_d = StWaito;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StWaito: begin
                if (all_valid) begin
                    state_d = StDrain;
                    rd_d    = 1'b1;
                    cnt_d   = CW'(1);
                    wcnt_d  = '0;
                end
            end
            StDrain: begin
                // cnt counts reads issued, wcnt indexes the next pmem write.
                wr_d = rd_q;
                if (wr_q) wcnt_d = wcnt_q + 1'b1;
                if (all_valid && (cnt_q < n_ext_q)) begin
                    rd_d  = 1'b1;
                    cnt_d = cnt_q + 1'b1;
                end
                if (wr_q && (wcnt_q == n_ext_q - 1'b1)) begin
                    cnt_d = '0;
`ifdef CORE_SEQ_ACC_EN
                    state_d = StAcc;
`else
                    state_d = StDone;
`endif
                end
            end
`ifdef CORE_SEQ_ACC_EN
            StAcc: begin
                ph_d = ~ph_q;
                if (ph_q) begin
                    if (cnt_q == n_ext_q - 1'b1) begin
                        state_d = StDone;
                        cnt_d   = '0;
                        ph_d    = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`endif
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output decode from next-state values so the registered word matches its phase.
    always_comb begin
        inst_d = IdleInst;
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
        unique case (state_d)
            StWrd: begin
                if (cnt_d < CW'(row)) begin
                    inst_d[19]   = 1'b0;
                    inst_d[17:7] = w_base_d + cnt_d[addr_bw-1:0];
                end
                inst_d[2] = (cnt_d != '0);
            end
            StWker: begin
                inst_d[0] = 1'b1;
                inst_d[3] = 1'b1;
            end
            StArd: begin
                if (cnt_d < n_ext_d) begin
                    inst_d[19]   = 1'b0;
                    inst_d[17:7] = a_base_d + cnt_d[addr_bw-1:0];
                end
                inst_d[2] = (cnt_d != '0);
            end
            StExec: begin
                inst_d[1] = 1'b1;
                inst_d[3] = 1'b1;
            end
            StDrain: begin
                inst_d[6] = rd_d;
                if (wr_d) begin
                    inst_d[32]    = 1'b0;
                    inst_d[31]    = 1'b0;
                    inst_d[30:20] = p_base_d + wcnt_d[addr_bw-1:0];
                end
            end
`ifdef CORE_SEQ_ACC_EN
            StAcc: begin
                inst_d[32]    = 1'b0;
                inst_d[31]    = ~ph_d;
                inst_d[33]    = ph_d;
                inst_d[30:20] = p_base_d + cnt_d[addr_bw-1:0];
            end
`endif
            default: inst_d = IdleInst;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            wcnt_q   <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            w_base_q <= '0;
            a_base_q <= '0;
            p_base_q <= '0;
            n_act_q  <= '0;
            inst_q   <= IdleInst;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef CORE_SEQ_ACC_EN
            ph_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wcnt_q   <= wcnt_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            w_base_q <= w_base_d;
            a_base_q <= a_base_d;
            p_base_q <= p_base_d;
            n_act_q  <= n_act_d;
            inst_q   <= inst_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef CORE_SEQ_ACC_EN
            ph_q     <= ph_d;
`endif
        end
    end

    assign bus.inst = inst_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule
